cam_pixel_assembler: RTL
========================

Name: cam_pixel_assembler

Overview:
Converts the double-flopped raw camera bus (camera clock, vsync, href, 8-bit data, all already synchronized to clk_pixel_in) into framed 16-bit RGB565 pixels with hcount/vcount and a single-cycle valid pulse. It sits directly upstream of the frame-buffer write port (port A address = hcount + H_PIXELS*vcount). It also reports frame completion and frame integrity.

Parameters:
H_PIXELS, 320, pixels per line (each pixel is two bytes)
V_LINES, 240, lines per frame

Ports:
clk_pixel_in  input  1  system pixel clock (74.25 MHz)
rst_in  input  1  asynchronous, active-high reset
cam_clk_in  input  1  synchronized camera PCLK (level, sampled each clk_pixel_in)
vsync_in  input  1  synchronized camera VSYNC (high = vertical blank)
href_in  input  1  synchronized camera HREF (high = line active)
pixel_in  input  8  synchronized camera data byte
pixel_out  output  16  assembled RGB565 pixel {first byte, second byte}
pixel_valid_out  output  1  single-cycle strobe; pixel_out/hcount_out/vcount_out valid
hcount_out  output  11  column of the emitted pixel, 0..H_PIXELS-1
vcount_out  output  10  row of the emitted pixel, 0..V_LINES-1
frame_done_out  output  1  single-cycle pulse at end of frame
frame_ok_out  output  1  integrity of the most recently completed frame (level)

Behaviour:
- Reset (async, rst_in=1): all outputs 0; state SYNC; byte phase 0; internal h/v counters 0; edge-detect history registers 0; error flag clear.
- cam_edge = cam_clk_in & ~cam_clk_prev (cam_clk_prev registered each cycle). All data capture happens only in cycles where cam_edge=1, using vsync_in/href_in/pixel_in from that same cycle.
- vsync_rise = vsync_in & ~vsync_prev, evaluated every cycle (not gated by cam_edge).
- States:
  - SYNC: discards everything until vsync_rise, then goes to BLANK. No frame_done_out on this first rise.
  - BLANK: vsync high. On vsync_in=0, go to ACTIVE with h=0, v=0, phase 0, error clear.
  - ACTIVE: byte assembly.
    - cam_edge & href_in & phase 0: latch byte as high half; phase to 1.
    - cam_edge & href_in & phase 1: form pixel; phase to 0. If h<H_PIXELS and v<V_LINES, emit it; otherwise drop it and set the error flag. Then h++ (saturating at 2047).
    - cam_edge & ~href_in & href_prev_sampled (href falls between successive edges): end of line.
      - If h!=H_PIXELS or phase=1, set the error flag.
      - Then h=0, phase 0, v++ (saturating at 1023).
    - vsync_rise: frame_done_out=1 for exactly one cycle.
      - frame_ok_out <= ~error & (v==V_LINES) & (phase==0).
      - State goes to BLANK.
      - A partial line (h!=0) counts as an error.
- Emit timing: pixel_valid_out, pixel_out, hcount_out and vcount_out are registered and asserted in the cycle after the cam_edge that captured the second byte. pixel_out/hcount_out/vcount_out hold between strobes. pixel_valid_out is never high on two consecutive cycles.
- Simultaneous events:
  - If vsync_rise and a second-byte capture occur in the same cycle, the pixel is dropped (vsync has priority) and counted as an error.
  - frame_done_out and pixel_valid_out are never high together.
- rst_in asserted mid-frame: immediate return to SYNC. frame_ok_out clears to 0. No frame_done_out is produced for the aborted frame.
- No backpressure: downstream must accept every strobe (BRAM write).

Test Plan:
- Reset, then vsync pulse, then 2 lines × 3 pixels (H_PIXELS=3, V_LINES=2), bytes 0x12,0x34,… then vsync rise.
  - Pixels 0x1234, 0x5678, 0x9ABC at (h,v)=(0,0),(1,0),(2,0), then (0,1)…(2,1).
  - Each strobe occurs 1 clk after the second-byte edge.
  - Then frame_done_out for 1 cycle with frame_ok_out=1.
- Same frame but before the first vsync after reset: no pixel_valid_out and no frame_done_out. The second frame is then framed normally.
- Line with 4 pixels (H_PIXELS=3): the 4th pixel is not emitted; frame_done_out pulses with frame_ok_out=0.
- Line with an odd byte count (7 bytes): 3 pixels emitted; the trailing byte is discarded at the href fall; frame_ok_out=0; the next line starts at h=0 with the correct byte pairing.
- Only 1 of 2 lines before vsync rise: frame_ok_out=0. The next full frame gives frame_ok_out=1 (error flag cleared on entry to ACTIVE).
- rst_in pulsed mid-line after 1.5 pixels:
  - All outputs go to 0 asynchronously and no frame_done_out follows.
  - A later vsync then full frame yields correct pixels from (0,0).

Source files
------------

// File: rtl/cam_pixel_assembler.sv
// cam_pixel_assembler
//   Turns the synchronized camera bus (PCLK level, VSYNC, HREF, 8-bit data)
//   into framed RGB565 pixels with column/row coordinates. It also reports
//   frame completion and frame integrity.
//
//   Ports
//     clk_pixel_in    : system pixel clock
//     rst_in          : asynchronous active-high reset
//     cam_clk_in      : synchronized camera PCLK level
//     vsync_in        : synchronized VSYNC (high = vertical blank)
//     href_in         : synchronized HREF (high = line active)
//     pixel_in        : synchronized camera data byte
//     pixel_out       : assembled pixel {first byte, second byte}
//     pixel_valid_out : one-cycle strobe qualifying pixel/hcount/vcount
//     hcount_out      : column of the emitted pixel
//     vcount_out      : row of the emitted pixel
//     frame_done_out  : one-cycle pulse at the end of a framed frame
//     frame_ok_out    : integrity of the last completed frame (level)
module cam_pixel_assembler #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic        cam_clk_in,
  input  logic        vsync_in,
  input  logic        href_in,
  input  logic [7:0]  pixel_in,
  output logic [15:0] pixel_out,
  output logic        pixel_valid_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        frame_done_out,
  output logic        frame_ok_out
);

  localparam logic [10:0] H_LIM = 11'(H_PIXELS);
  localparam logic [9:0]  V_LIM = 10'(V_LINES);

  typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} state_t;

  state_t      state, state_n;
  logic        cam_clk_prev;
  logic        vsync_prev;
  logic        href_prev, href_prev_n;
  logic        phase, phase_n;
  logic [7:0]  hi_byte, hi_byte_n;
  logic [10:0] h, h_n;
  logic [9:0]  v, v_n;
  logic        err, err_n;

  logic [15:0] pixel_n;
  logic        valid_n;
  logic [10:0] hcount_n;
  logic [9:0]  vcount_n;
  logic        done_n;
  logic        ok_n;

  logic cam_edge;
  logic vsync_rise;

  assign cam_edge   = cam_clk_in & ~cam_clk_prev;
  assign vsync_rise = vsync_in & ~vsync_prev;

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= SYNC;
      cam_clk_prev    <= 1'b0;
      vsync_prev      <= 1'b0;
      href_prev       <= 1'b0;
      phase           <= 1'b0;
      hi_byte         <= '0;
      h               <= '0;
      v               <= '0;
      err             <= 1'b0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_done_out  <= 1'b0;
      frame_ok_out    <= 1'b0;
    end else begin
      state           <= state_n;
      cam_clk_prev    <= cam_clk_in;
      vsync_prev      <= vsync_in;
      href_prev       <= href_prev_n;
      phase           <= phase_n;
      hi_byte         <= hi_byte_n;
      h               <= h_n;
      v               <= v_n;
      err             <= err_n;
      pixel_out       <= pixel_n;
      pixel_valid_out <= valid_n;
      hcount_out      <= hcount_n;
      vcount_out      <= vcount_n;
      frame_done_out  <= done_n;
      frame_ok_out    <= ok_n;
    end
  end

  always_comb begin
    state_n     = state;
    href_prev_n = cam_edge ? href_in : href_prev;
    phase_n     = phase;
    hi_byte_n   = hi_byte;
    h_n         = h;
    v_n         = v;
    err_n       = err;
    pixel_n     = pixel_out;
    valid_n     = 1'b0;
    hcount_n    = hcount_out;
    vcount_n    = vcount_out;
    done_n      = 1'b0;
    ok_n        = frame_ok_out;

    unique case (state)
      SYNC: begin
        if (vsync_rise) state_n = BLANK;
      end

      BLANK: begin
        if (!vsync_in) begin
          state_n = ACTIVE;
          h_n     = '0;
          v_n     = '0;
          phase_n = 1'b0;
          err_n   = 1'b0;
        end
      end

      ACTIVE: begin
        if (vsync_rise) begin
          // VSYNC wins over any byte captured in the same cycle. A dropped
          // second byte implies phase==1, which already fails the frame; a
          // line left partial (h!=0) also fails it.
          done_n  = 1'b1;
          ok_n    = ~err & (v == V_LIM) & ~phase & (h == '0);
          state_n = BLANK;
        end else if (cam_edge) begin
          if (href_in) begin
            if (!phase) begin
              hi_byte_n = pixel_in;
              phase_n   = 1'b1;
            end else begin
              phase_n = 1'b0;
              if (h < H_LIM && v < V_LIM) begin
                pixel_n  = {hi_byte, pixel_in};
                valid_n  = 1'b1;
                hcount_n = h;
                vcount_n = v;
              end else begin
                err_n = 1'b1;
              end
              if (h != '1) h_n = h + 11'd1;
            end
          end else if (href_prev) begin
            if (h != H_LIM || phase) err_n = 1'b1;
            h_n     = '0;
            phase_n = 1'b0;
            if (v != '1) v_n = v + 10'd1;
          end
        end
      end

      default: state_n = SYNC;
    endcase
  end

endmodule
